// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the fifo_sync write-port arbiter.
// Two-state packet lock FSM and the packet counter width.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo N.
// Zero latency; no flow control of its own.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] index
);

  logic [N-1:0] rot;
  logic         hit;
  int           start;
  int           pos;

  // Rotate a doubled copy so the search always starts at bit 0, then map back.
  always_comb begin
    start = (int'(ptr) + 1) % N;
    rot   = N'({req, req} >> start);
    hit   = 1'b0;
    pos   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        hit = 1'b1;
        pos = (start + i) % N;
      end
    end
    index = CW'(pos);
    grant = '0;
    if (hit) grant[index] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter sharing one fifo_sync write port; zero-latency grant/write.
// Full stalls every client; almost-full only blocks new packet starts.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_CLIENTS       = 4,
  parameter int DATA_WIDTH      = 8,
  parameter bit USE_ALMOST_FULL = 1'b1,
  localparam int CW             = $clog2(N_CLIENTS)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [N_CLIENTS-1:0]            i_req,
  input  logic [N_CLIENTS-1:0]            i_req_last,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0] i_req_data,
  output logic [N_CLIENTS-1:0]            ow_grant,
  output logic                            ow_fifo_write,
  output logic [DATA_WIDTH-1:0]           ow_fifo_wr_data,
  input  logic                            i_fifo_wr_full,
  input  logic                            i_fifo_wr_almost_full,
  output logic                            o_locked,
  output logic [CW-1:0]                   o_owner,
  output logic [PKT_CNT_W-1:0]            o_pkt_count
);

  arb_state_t           state, state_nxt;
  logic [CW-1:0]        r_last, last_nxt, owner_nxt;
  logic [PKT_CNT_W-1:0] cnt_nxt;
  logic [N_CLIENTS-1:0] cand, pick_grant;
  logic [CW-1:0]        pick_idx, win_idx;
  logic                 throttle, fire, win_last;

  always_comb begin
    throttle = i_fifo_wr_full || (USE_ALMOST_FULL && i_fifo_wr_almost_full);
    cand     = throttle ? '0 : i_req;
  end

  rr_priority_pick #(
    .N  (N_CLIENTS),
    .CW (CW)
  ) u_pick (
    .req   (cand),
    .ptr   (r_last),
    .grant (pick_grant),
    .index (pick_idx)
  );

  // While locked only the owner can be served, and almost-full is ignored.
  always_comb begin
    ow_grant = '0;
    win_idx  = pick_idx;
    if (!i_rst) begin
      if (state == ARB_IDLE) begin
        ow_grant = pick_grant;
      end else begin
        win_idx           = o_owner;
        ow_grant[o_owner] = i_req[o_owner] && !i_fifo_wr_full;
      end
    end
    fire            = |(ow_grant & i_req);
    win_last        = i_req_last[win_idx];
    ow_fifo_write   = fire;
    ow_fifo_wr_data = fire ? i_req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = o_owner;
    last_nxt  = r_last;
    cnt_nxt   = o_pkt_count;
    case (state)
      ARB_IDLE: begin
        if (fire) begin
          owner_nxt = win_idx;
          if (win_last) begin
            last_nxt = win_idx;
            cnt_nxt  = o_pkt_count + 1'b1;
          end else begin
            state_nxt = ARB_LOCK;
          end
        end
      end
      ARB_LOCK: begin
        if (fire && win_last) begin
          state_nxt = ARB_IDLE;
          last_nxt  = o_owner;
          cnt_nxt   = o_pkt_count + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Reset abandons any packet in flight; r_last starts at the top so client 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ARB_IDLE;
      o_owner     <= '0;
      r_last      <= CW'(N_CLIENTS - 1);
      o_pkt_count <= '0;
    end else begin
      state       <= state_nxt;
      o_owner     <= owner_nxt;
      r_last      <= last_nxt;
      o_pkt_count <= cnt_nxt;
    end
  end

  assign o_locked = (state == ARB_LOCK);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(ow_fifo_write && i_fifo_wr_full))
        else $error("fifo_wr_arbiter: write issued while fifo full");
      assert ($onehot0(ow_grant))
        else $error("fifo_wr_arbiter: grant not onehot0: %b", ow_grant);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized packet traffic,
// every cycle checked against a queue-free behavioural packet model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic [N-1:0]    i_req = '0;
  logic [N-1:0]    i_req_last = '0;
  logic [N*DW-1:0] i_req_data = '0;
  logic            i_fifo_wr_full = 1'b0;
  logic            i_fifo_wr_almost_full = 1'b0;
  logic [N-1:0]    ow_grant;
  logic            ow_fifo_write;
  logic [DW-1:0]   ow_fifo_wr_data;
  logic            o_locked;
  logic [1:0]      o_owner;
  logic [15:0]     o_pkt_count;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  fifo_wr_arbiter #(
    .N_CLIENTS       (N),
    .DATA_WIDTH      (DW),
    .USE_ALMOST_FULL (1'b1)
  ) dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_req                 (i_req),
    .i_req_last            (i_req_last),
    .i_req_data            (i_req_data),
    .ow_grant              (ow_grant),
    .ow_fifo_write         (ow_fifo_write),
    .ow_fifo_wr_data       (ow_fifo_wr_data),
    .i_fifo_wr_full        (i_fifo_wr_full),
    .i_fifo_wr_almost_full (i_fifo_wr_almost_full),
    .o_locked              (o_locked),
    .o_owner               (o_owner),
    .o_pkt_count           (o_pkt_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: owner of the open packet (-1 = none), last winner, reported owner, count.
  int          m_owner = -1;
  int          m_ptr = N - 1;
  int          m_own_reg = 0;
  logic [15:0] m_cnt = '0;
  bit          m_valid = 1'b0;
  int          w;

  function automatic int exp_winner();
    if (i_rst || i_fifo_wr_full) return -1;
    if (m_owner >= 0) return i_req[m_owner] ? m_owner : -1;
    if (i_fifo_wr_almost_full) return -1;
    for (int k = 1; k <= N; k++) begin
      if (i_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(negedge i_clk);
      #2;
      if (i_rst) begin
        chk("rst_grant", 32'(ow_grant), 32'h0);
        chk("rst_write", 32'(ow_fifo_write), 32'h0);
        chk("rst_data", 32'(ow_fifo_wr_data), 32'h0);
        m_owner   = -1;
        m_ptr     = N - 1;
        m_own_reg = 0;
        m_cnt     = '0;
        m_valid   = 1'b1;
      end else if (m_valid) begin
        w = exp_winner();
        chk("grant", 32'(ow_grant), (w >= 0) ? (32'h1 << w) : 32'h0);
        chk("write", 32'(ow_fifo_write), (w >= 0) ? 32'h1 : 32'h0);
        chk("wr_data", 32'(ow_fifo_wr_data), (w >= 0) ? 32'(i_req_data[w*DW +: DW]) : 32'h0);
        chk("locked", 32'(o_locked), (m_owner >= 0) ? 32'h1 : 32'h0);
        chk("owner", 32'(o_owner), 32'(m_own_reg));
        chk("pkt_count", 32'(o_pkt_count), 32'(m_cnt));
        if (w >= 0) begin
          m_own_reg = w;
          if (i_req_last[w]) begin
            m_cnt   = m_cnt + 16'd1;
            m_ptr   = w;
            m_owner = -1;
          end else begin
            m_owner = w;
          end
        end
      end
    end
  end

  // Inputs change on the falling edge; caller samples 3 time units later.
  task automatic cyc(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] lst,
                     input logic [N*DW-1:0] dat, input logic full, input logic af);
    @(negedge i_clk);
    i_rst                 = rst;
    i_req                 = rq;
    i_req_last            = lst;
    i_req_data            = dat;
    i_fifo_wr_full        = full;
    i_fifo_wr_almost_full = af;
    #3;
  endtask

  int         rem [N];
  logic [7:0] seq [N];

  initial begin
    cyc(1'b1, 4'h0, 4'h0, '0, 1'b0, 1'b0);

    // 1: all clients, single-beat packets, rotate 0..3 twice
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'hF, 4'hF, {8'h33, 8'h22, 8'h11, 8'h00}, 1'b0, 1'b0);
      chk("t1_grant", 32'(ow_grant), 32'h1 << (i % 4));
    end
    cyc(1'b0, 4'h0, 4'h0, '0, 1'b0, 1'b0);
    chk("t1_count", 32'(o_pkt_count), 32'd8);

    // 2: client 2 three-beat packet, client 0 waiting
    cyc(1'b0, 4'b0100, 4'b0000, {8'h00, 8'hA0, 8'h00, 8'h55}, 1'b0, 1'b0);
    chk("t2_d0", 32'(ow_fifo_wr_data), 32'hA0);
    cyc(1'b0, 4'b0101, 4'b0001, {8'h00, 8'hA1, 8'h00, 8'h55}, 1'b0, 1'b0);
    chk("t2_d1", 32'(ow_fifo_wr_data), 32'hA1);
    chk("t2_lock1", 32'(o_locked), 32'h1);
    cyc(1'b0, 4'b0101, 4'b0101, {8'h00, 8'hA2, 8'h00, 8'h55}, 1'b0, 1'b0);
    chk("t2_d2", 32'(ow_fifo_wr_data), 32'hA2);
    chk("t2_lock2", 32'(o_locked), 32'h1);
    cyc(1'b0, 4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h55}, 1'b0, 1'b0);
    chk("t2_c0", 32'(ow_grant), 32'b0001);
    chk("t2_unlock", 32'(o_locked), 32'h0);

    // 3: almost-full lets the owner finish but holds off client 3
    cyc(1'b0, 4'b0010, 4'b0000, {8'h30, 8'h00, 8'hB0, 8'h00}, 1'b0, 1'b0);
    cyc(1'b0, 4'b1010, 4'b1000, {8'h30, 8'h00, 8'hB1, 8'h00}, 1'b0, 1'b1);
    chk("t3_af_cont", 32'(ow_grant), 32'b0010);
    cyc(1'b0, 4'b1010, 4'b1010, {8'h30, 8'h00, 8'hB2, 8'h00}, 1'b0, 1'b1);
    chk("t3_af_last", 32'(ow_fifo_wr_data), 32'hB2);
    cyc(1'b0, 4'b1000, 4'b1000, {8'h30, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1);
    chk("t3_af_block", 32'(ow_grant), 32'h0);
    cyc(1'b0, 4'b1000, 4'b1000, {8'h30, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0);
    chk("t3_c3", 32'(ow_grant), 32'b1000);

    // 4: full for three cycles mid-packet
    cyc(1'b0, 4'b0001, 4'b0000, {24'h0, 8'hC0}, 1'b0, 1'b0);
    cyc(1'b0, 4'b0001, 4'b0000, {24'h0, 8'hC1}, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b0001, 4'b0001, {24'h0, 8'hC2}, 1'b1, 1'b0);
      chk("t4_full_wr", 32'(ow_fifo_write), 32'h0);
      chk("t4_full_lock", 32'(o_locked), 32'h1);
    end
    cyc(1'b0, 4'b0001, 4'b0001, {24'h0, 8'hC2}, 1'b0, 1'b0);
    chk("t4_resume", 32'(ow_fifo_wr_data), 32'hC2);

    // 5: owner bubble while others request
    cyc(1'b0, 4'b0010, 4'b0000, {16'h0, 8'hD0, 8'h0}, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 4'b1101, 4'b1101, {16'h0, 8'h00, 8'h0}, 1'b0, 1'b0);
      chk("t5_bubble", 32'(ow_grant), 32'h0);
      chk("t5_lock", 32'(o_locked), 32'h1);
    end
    cyc(1'b0, 4'b1111, 4'b0010, {16'h0, 8'hD1, 8'h0}, 1'b0, 1'b0);
    chk("t5_finish", 32'(ow_grant), 32'b0010);

    // 6: reset while locked
    cyc(1'b0, 4'b0100, 4'b0000, {8'h0, 8'hE0, 16'h0}, 1'b0, 1'b0);
    cyc(1'b1, 4'b0100, 4'b0000, {8'h0, 8'hE1, 16'h0}, 1'b0, 1'b0);
    cyc(1'b0, 4'b1010, 4'b1010, {8'h3E, 8'h0, 8'h1E, 8'h0}, 1'b0, 1'b0);
    chk("t6_locked", 32'(o_locked), 32'h0);
    chk("t6_owner", 32'(o_owner), 32'h0);
    chk("t6_count", 32'(o_pkt_count), 32'h0);
    chk("t6_grant", 32'(ow_grant), 32'b0010);

    // Randomized multi-beat traffic with bubbles, full, almost-full and rare resets
    for (int k = 0; k < N; k++) begin
      rem[k] = 0;
      seq[k] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clk);
      i_rst                 = ($urandom_range(0, 299) == 0);
      i_fifo_wr_full        = ($urandom_range(0, 9) == 0);
      i_fifo_wr_almost_full = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < N; k++) begin
        if (rem[k] == 0 && $urandom_range(0, 2) == 0) rem[k] = $urandom_range(1, 4);
        i_req[k]              = (rem[k] != 0) && ($urandom_range(0, 7) != 0);
        i_req_last[k]         = (rem[k] == 0) ? 1'($urandom_range(0, 1)) : (rem[k] == 1);
        i_req_data[k*DW +: DW] = 8'((k << 6) | (int'(seq[k]) & 63));
      end
      #4;
      for (int k = 0; k < N; k++) begin
        if (i_req[k] && ow_grant[k]) begin
          rem[k] = rem[k] - 1;
          seq[k] = seq[k] + 8'd1;
        end
      end
    end

    @(negedge i_clk);
    i_req = '0;
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
